// File: rtl/nx_stream_distributor.sv
// nx_stream_distributor: routes one inbound message stream through a single holding
// register into four per-direction FIFOs; a full target FIFO blocks only the inbound side.
module nx_stream_distributor #(
    parameter int STREAM_WIDTH = 32,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [STREAM_WIDTH-1:0] dist_data_i,
    input  logic [1:0]              dist_dir_i,
    input  logic                    dist_valid_i,
    output logic                    dist_ready_o,
    output logic [STREAM_WIDTH-1:0] north_data_o,
    output logic                    north_valid_o,
    input  logic                    north_ready_i,
    output logic [STREAM_WIDTH-1:0] east_data_o,
    output logic                    east_valid_o,
    input  logic                    east_ready_i,
    output logic [STREAM_WIDTH-1:0] south_data_o,
    output logic                    south_valid_o,
    input  logic                    south_ready_i,
    output logic [STREAM_WIDTH-1:0] west_data_o,
    output logic                    west_valid_o,
    input  logic                    west_ready_i,
    output logic                    idle_o
);

    localparam int NUM_DIRS = 4;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LEVEL_W  = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(FIFO_DEPTH - 1)) return '0;
        return ptr + PTR_W'(1);
    endfunction

    function automatic logic [LEVEL_W-1:0] next_level(input logic [LEVEL_W-1:0] lvl,
                                                      input logic inc, input logic dec);
        case ({inc, dec})
            2'b10:   return lvl + LEVEL_W'(1);
            2'b01:   return lvl - LEVEL_W'(1);
            default: return lvl;
        endcase
    endfunction

    logic                    run_p0;
    logic                    hold_vld_p0;
    logic [STREAM_WIDTH-1:0] hold_data_p0;
    logic [1:0]              hold_dir_p0;

    logic [STREAM_WIDTH-1:0] fifo_mem_p1 [NUM_DIRS][FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_p1   [NUM_DIRS];
    logic [PTR_W-1:0]        wr_ptr_p1   [NUM_DIRS];
    logic [LEVEL_W-1:0]      level_p1    [NUM_DIRS];

    logic [NUM_DIRS-1:0]     out_ready;
    logic [NUM_DIRS-1:0]     out_valid;
    logic [NUM_DIRS-1:0]     pop;
    logic [NUM_DIRS-1:0]     can_push;
    logic [NUM_DIRS-1:0]     push;
    logic [STREAM_WIDTH-1:0] out_data    [NUM_DIRS];
    logic                    fifo_empty_all;
    logic                    drain;
    logic                    load;

    assign out_ready = {west_ready_i, south_ready_i, east_ready_i, north_ready_i};

    // A full FIFO still accepts when its head leaves in the same cycle
    always_comb begin
        out_valid      = '0;
        pop            = '0;
        can_push       = '0;
        push           = '0;
        fifo_empty_all = 1'b1;
        for (int d = 0; d < NUM_DIRS; d++) begin
            out_valid[d] = (level_p1[d] != '0);
            pop[d]       = out_valid[d] & out_ready[d];
            can_push[d]  = (level_p1[d] < LEVEL_W'(FIFO_DEPTH)) |
                           ((level_p1[d] == LEVEL_W'(FIFO_DEPTH)) & pop[d]);
            push[d]      = hold_vld_p0 & (hold_dir_p0 == 2'(d)) & can_push[d];
            out_data[d]  = out_valid[d] ? fifo_mem_p1[d][rd_ptr_p1[d]] : '0;
            if (out_valid[d]) fifo_empty_all = 1'b0;
        end
    end

    assign drain        = |push;
    assign dist_ready_o = run_p0 & (~hold_vld_p0 | drain);
    assign load         = dist_valid_i & dist_ready_o;
    assign idle_o       = ~hold_vld_p0 & fifo_empty_all;

    // Stage p0: holding register control; run_p0 keeps ready low until the first edge after reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            run_p0      <= 1'b0;
            hold_vld_p0 <= 1'b0;
        end else begin
            run_p0 <= 1'b1;
            if (load) begin
                hold_vld_p0 <= 1'b1;
            end else if (drain) begin
                hold_vld_p0 <= 1'b0;
            end
        end
    end

    // Stage p1: per-direction FIFO pointers and levels
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int d = 0; d < NUM_DIRS; d++) begin
                rd_ptr_p1[d] <= '0;
                wr_ptr_p1[d] <= '0;
                level_p1[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < NUM_DIRS; d++) begin
                if (pop[d])  rd_ptr_p1[d] <= next_ptr(rd_ptr_p1[d]);
                if (push[d]) wr_ptr_p1[d] <= next_ptr(wr_ptr_p1[d]);
                level_p1[d] <= next_level(level_p1[d], push[d], pop[d]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (load) begin
            hold_data_p0 <= dist_data_i;
            hold_dir_p0  <= dist_dir_i;
        end
        for (int d = 0; d < NUM_DIRS; d++) begin
            if (push[d]) fifo_mem_p1[d][wr_ptr_p1[d]] <= hold_data_p0;
        end
    end

    assign north_data_o  = out_data[0];
    assign east_data_o   = out_data[1];
    assign south_data_o  = out_data[2];
    assign west_data_o   = out_data[3];
    assign north_valid_o = out_valid[0];
    assign east_valid_o  = out_valid[1];
    assign south_valid_o = out_valid[2];
    assign west_valid_o  = out_valid[3];

endmodule
